// File: rtl/excp_flush_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// excp_flush_ctrl_pkg
//   Shared definitions for the exception/eret flush controller:
//     - controller state encoding
//     - reset value of the latched redirect pc
//     - exception-type field widths used by CP0 and the pipeline
//     - writeback-kill select helper
// ---------------------------------------------------------------------------
package excp_flush_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_REDIRECT = 2'd3
  } excp_state_e;

  localparam logic [31:0] EXCP_RESET_PC = 32'h0000_0000;

  // Exception-type fields carried alongside a request.
  localparam int EXCCODE_W  = 5;
  localparam int EXCTYPE_W  = 4;
  localparam int FLUSH_CNT_W = 4;

  // Lane 1 faulting kills both lanes (lane 2 is younger); lane 2 alone only
  // kills itself. An unattributed request (e.g. interrupt) kills both.
  function automatic logic [1:0] wb_kill_sel(input logic by_i1, input logic by_i2);
    if (by_i1)      return 2'b11;
    else if (by_i2) return 2'b10;
    else            return 2'b11;
  endfunction

endpackage

// File: rtl/excp_flush_ctrl.sv
// ---------------------------------------------------------------------------
// excp_flush_ctrl
//   Sequences a CP0 exception/eret: optionally waits for a MEM stall to clear,
//   flushes IF/ID/EX/MEM for FLUSH_CYCLES cycles, and offers the redirect pc
//   to IF until accepted.
//
// Ports
//   clk, rst               clock, async active-low reset
//   excp_req, excp_pc      flush request and redirect target from CP0
//   caused_by_i1/_i2       originating lane of the request
//   mem_stall              MEM frozen by a D-cache miss
//   fetch_ready            IF accepts a redirect this cycle
//   flush_if/id/ex/mem     stage-register flushes
//   wb_kill[1:0]           same-cycle writeback suppression, lane2:lane1
//   redirect_valid/_pc     redirect offer to IF
//   excp_busy              controller not idle
// ---------------------------------------------------------------------------
module excp_flush_ctrl
  import excp_flush_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        excp_req,
  input  logic [31:0] excp_pc,
  input  logic        caused_by_i1,
  input  logic        caused_by_i2,
  input  logic        mem_stall,
  input  logic        fetch_ready,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        flush_mem,
  output logic [1:0]  wb_kill,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        excp_busy
);

  localparam logic [FLUSH_CNT_W-1:0] CNT_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  excp_state_e            state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]            pc_q, pc_d;
  logic                   acc_q, acc_d;
  logic                   flush_all;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pc_q    <= EXCP_RESET_PC;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_d           = pc_q;
    acc_d          = acc_q;
    flush_all      = 1'b0;
    redirect_valid = 1'b0;
    wb_kill        = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (excp_req) begin
          pc_d    = excp_pc;
          wb_kill = wb_kill_sel(caused_by_i1, caused_by_i2);
          if (mem_stall) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (!mem_stall) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_FLUSH: begin
        flush_all      = 1'b1;
        redirect_valid = 1'b1;
        if (cnt_q == '0) begin
          // Leave flush; skip REDIRECT if IF already took the pc.
          if (acc_q || fetch_ready) begin
            state_d = ST_IDLE;
            acc_d   = 1'b0;
          end else begin
            state_d = ST_REDIRECT;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (fetch_ready) acc_d = 1'b1;
        end
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        if (fetch_ready) begin
          state_d = ST_IDLE;
          acc_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // wb_kill is a combinational path from excp_req; hold it off during reset.
    if (!rst) wb_kill = 2'b00;
  end

  assign flush_if    = flush_all;
  assign flush_id    = flush_all;
  assign flush_ex    = flush_all;
  assign flush_mem   = flush_all;
  assign redirect_pc = redirect_valid ? pc_q : EXCP_RESET_PC;
  assign excp_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_excp_flush_ctrl.sv
module tb_excp_flush_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        excp_req, caused_by_i1, caused_by_i2, mem_stall, fetch_ready;
  logic [31:0] excp_pc;
  logic        flush_if, flush_id, flush_ex, flush_mem;
  logic [1:0]  wb_kill;
  logic        redirect_valid, excp_busy;
  logic [31:0] redirect_pc;

  int n_vec = 0;
  int n_err = 0;

  excp_flush_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .excp_req(excp_req), .excp_pc(excp_pc),
    .caused_by_i1(caused_by_i1), .caused_by_i2(caused_by_i2),
    .mem_stall(mem_stall), .fetch_ready(fetch_ready),
    .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
    .flush_mem(flush_mem), .wb_kill(wb_kill),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .excp_busy(excp_busy)
  );

  always #5 clk = ~clk;

  // Reference model: a request in flight is described by whether it is
  // waiting out a stall, how many flush cycles remain, and whether IF has
  // yet to take the redirect.
  bit          m_wait_stall;
  int          m_flush_left;
  bit          m_pending;
  logic [31:0] m_pc;

  function automatic bit m_idle();
    return !m_wait_stall && m_flush_left == 0 && !m_pending;
  endfunction

  task automatic m_reset();
    m_wait_stall = 0; m_flush_left = 0; m_pending = 0; m_pc = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit          fl, rv;
    logic [1:0]  wk;
    fl = (m_flush_left > 0);
    rv = fl || (m_pending && !m_wait_stall);
    wk = 2'b00;
    if (m_idle() && excp_req && rst)
      wk = caused_by_i1 ? 2'b11 : (caused_by_i2 ? 2'b10 : 2'b11);
    chk("flush_if",  {31'b0, flush_if},  {31'b0, fl});
    chk("flush_id",  {31'b0, flush_id},  {31'b0, fl});
    chk("flush_ex",  {31'b0, flush_ex},  {31'b0, fl});
    chk("flush_mem", {31'b0, flush_mem}, {31'b0, fl});
    chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, rv});
    chk("redirect_pc", redirect_pc, rv ? m_pc : 32'h0);
    chk("excp_busy", {31'b0, excp_busy}, {31'b0, !m_idle()});
    chk("wb_kill", {30'b0, wb_kill}, {30'b0, wk});
  endtask

  task automatic m_clock();
    bit rv;
    rv = (m_flush_left > 0) || (m_pending && !m_wait_stall);
    if (m_idle()) begin
      if (excp_req) begin
        m_pc = excp_pc; m_pending = 1;
        if (mem_stall) m_wait_stall = 1;
        else           m_flush_left = FC;
      end
    end else if (m_wait_stall) begin
      if (!mem_stall) begin m_wait_stall = 0; m_flush_left = FC; end
    end else begin
      if (rv && fetch_ready) m_pending = 0;
      if (m_flush_left > 0) m_flush_left--;
    end
  endtask

  task automatic step(input logic req, input logic [31:0] pc, input logic i1,
                      input logic i2, input logic st, input logic fr);
    excp_req = req; excp_pc = pc; caused_by_i1 = i1; caused_by_i2 = i2;
    mem_stall = st; fetch_ready = fr;
    @(negedge clk);
    check_all();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b0;
    excp_req = 0; excp_pc = '0; caused_by_i1 = 0; caused_by_i2 = 0;
    mem_stall = 0; fetch_ready = 0;
    m_reset();
    #2;
    check_all();                      // reset state before any edge
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);

    // Lane-1 exception, IF ready: two flush cycles then idle.
    step(1, 32'hbfc00380, 1, 0, 0, 1);
    chk("sc1_busy", {31'b0, excp_busy}, 32'd1);
    step(0, 32'h0, 0, 0, 0, 1);
    step(0, 32'h0, 0, 0, 0, 1);
    // Back-to-back: lane-2 request in first idle cycle.
    step(1, 32'h80001000, 0, 1, 0, 1);
    idle(3);

    // Request under a 3-cycle MEM stall.
    step(1, 32'h00400000, 1, 0, 1, 1);
    step(0, 32'h0, 0, 0, 1, 1);
    step(0, 32'h0, 0, 0, 1, 1);
    step(0, 32'h0, 0, 0, 0, 1);
    idle(4);

    // IF not ready for 5 cycles: REDIRECT holds pc stable.
    step(1, 32'h9abc0000, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0, 1);
    idle(2);

    // Second request during FLUSH is ignored.
    step(1, 32'h0badf00d, 1, 1, 0, 0);
    step(1, 32'h12345678, 1, 0, 0, 0);
    step(1, 32'h12345678, 0, 1, 0, 0);
    step(0, 32'h0, 0, 0, 0, 1);
    idle(2);

    // Reset while in REDIRECT: outputs clear without a clock edge.
    step(1, 32'hdeadbee0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 0, 0, 0);
    excp_req = 1; caused_by_i1 = 1;
    #1 rst = 1'b0;
    m_reset();
    #1;
    check_all();
    @(posedge clk); #1;
    rst = 1'b1;
    step(1, 32'hbfc00200, 1, 0, 0, 1);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 1),
           $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/excp_flush_ctrl.md
EXCP_FLUSH_CTRL -- requirements
Module: excp_flush_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: number of cycles the stage flushes stay asserted per exception/eret (legal 1..15).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- excp_req  in  1  exception/eret flush request from CP0.
- excp_pc  in  32  redirect target from CP0; valid with excp_req.
- caused_by_i1  in  1  request originates from lane 1.
- caused_by_i2  in  1  request originates from lane 2.
- mem_stall  in  1  MEM stage frozen by a data-cache miss.
- fetch_ready  in  1  IF accepts a redirect this cycle.
- flush_if, flush_id, flush_ex, flush_mem  out  1 each  stage-register flushes.
- wb_kill  out  2  [0] suppresses lane-1 writeback, [1] suppresses lane-2 writeback, same cycle.
- redirect_valid  out  1  redirect offered to IF.
- redirect_pc  out  32  redirect target.
- excp_busy  out  1  controller not idle; MEM blocks new commits.

Function
REQ-003 SHALL implement states IDLE, HOLD, FLUSH, REDIRECT.
REQ-004 In IDLE, excp_req=1 with mem_stall=0 SHALL latch excp_pc and go to FLUSH at the next edge.
REQ-005 In IDLE, excp_req=1 with mem_stall=1 SHALL latch excp_pc and go to HOLD.
REQ-006 HOLD SHALL stay while mem_stall=1 and go to FLUSH in the cycle after mem_stall falls; flushes stay 0 in HOLD.
REQ-007 On entering FLUSH, the flush counter SHALL load FLUSH_CYCLES-1; flush_if/id/ex/mem SHALL be 1 in every FLUSH cycle.
REQ-008 The counter SHALL decrement each FLUSH cycle and saturate at 0 (no wrap).
REQ-009 redirect_valid SHALL be 1 in FLUSH and REDIRECT, with redirect_pc equal to the latched excp_pc.
REQ-010 The redirect handshake SHALL complete when redirect_valid=1 and fetch_ready=1; redirect_pc SHALL stay stable until then.
REQ-011 FLUSH SHALL transition when the counter is 0: to IDLE if the handshake has completed (this cycle or earlier), else to REDIRECT.
REQ-012 REDIRECT SHALL go to IDLE on handshake completion; flushes are 0 in REDIRECT.
REQ-013 An accepted-redirect flag SHALL record a handshake completed earlier in FLUSH and clear on return to IDLE.
REQ-014 excp_busy SHALL be 1 in every state except IDLE.
REQ-015 excp_req SHALL be ignored outside IDLE; no second latch, no pc overwrite.
REQ-016 wb_kill SHALL be combinational and nonzero only when state=IDLE and excp_req=1:
- caused_by_i1=1 -> 2'b11.
- otherwise caused_by_i2=1 -> 2'b10.
- neither set -> 2'b11.
- caused_by_i1 has priority when both are set.
REQ-017 Latency SHALL be: excp_req sampled at edge N (IDLE, no stall) -> flushes and redirect_valid high after edge N+1.
REQ-018 Back-to-back: excp_req asserted in the first IDLE cycle after a return SHALL be accepted normally.

Reset
REQ-019 rst low SHALL immediately force:
- state IDLE, counter 0, latched pc 0, accepted flag 0.
- all flushes 0, redirect_valid 0, redirect_pc 32'h0, excp_busy 0, wb_kill 0.
REQ-020 Reset mid-operation (any state) SHALL abandon the redirect; the release edge is synchronised by the top level.

Structure
REQ-021 State encoding and the reset pc constant SHALL live in the shared defines header alongside the exception-type field widths.
REQ-022 The block SHALL be a single module; no sub-module is needed.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios:
- IDLE, excp_req=1, excp_pc=32'hbfc00380, caused_by_i1=1, fetch_ready=1 -> wb_kill=2'b11 same cycle; flushes high 2 cycles; redirect_pc=32'hbfc00380; IDLE after 2 cycles.
- excp_req with caused_by_i2=1 only, excp_pc=32'h80001000 -> wb_kill=2'b10; redirect_pc=32'h80001000.
- excp_req with mem_stall=1 for 3 cycles -> HOLD, flushes 0 for 3 cycles, excp_busy=1; FLUSH starts one cycle after stall falls.
- fetch_ready=0 for 5 cycles -> REDIRECT after 2 flush cycles; redirect_pc stable; IDLE the cycle after fetch_ready=1.
- second excp_req with excp_pc=32'h12345678 during FLUSH -> ignored, redirect_pc unchanged, wb_kill=0.
- rst asserted low in REDIRECT -> all outputs 0 immediately, without a clock edge; next excp_req after release handled normally.
